// File: rtl/multdiv_pkg.sv
// multdiv_pkg: shared widths, FSM encoding and helpers for the iterative multiply/divide unit
package multdiv_pkg;
  localparam int WIDTH = 32;
  localparam int CNT_W = 6;
  localparam logic [CNT_W-1:0] ITER_LAST = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] INT_MIN = 32'h8000_0000;
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_e;
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? WIDTH'(-v) : v;
  endfunction
endpackage

// File: rtl/multdiv_step.sv
// multdiv_step: one radix-2 Booth step or one non-restoring divide step sharing a single 33-bit add/sub
module multdiv_step
  import multdiv_pkg::*;
(
  input  logic               op_div,
  input  logic [2*WIDTH:0]   p_in,
  input  logic [WIDTH-1:0]   m_in,
  output logic [2*WIDTH:0]   p_out
);
  logic [WIDTH:0] a_op;
  logic [WIDTH:0] b_op;
  logic [WIDTH:0] sum;
  logic           sub;
  // MUL packs {acc,Q,q-1}; DIV packs {rem[32:0],quotient}; the 33-bit adder keeps the Booth acc from overflowing on INT_MIN
  always_comb begin
    a_op  = op_div ? {p_in[2*WIDTH-1:WIDTH], p_in[WIDTH-1]} : {p_in[2*WIDTH], p_in[2*WIDTH:WIDTH+1]};
    b_op  = op_div ? {1'b0, m_in} : ((p_in[1] ^ p_in[0]) ? {m_in[WIDTH-1], m_in} : '0);
    sub   = op_div ? ~p_in[2*WIDTH] : (p_in[1] & ~p_in[0]);
    sum   = sub ? a_op - b_op : a_op + b_op;
    p_out = op_div ? {sum, p_in[WIDTH-2:0], ~sum[WIDTH]} : {sum, p_in[WIDTH:1]};
  end
endmodule

// File: rtl/multdiv_iter.sv
// multdiv_iter: multi-cycle signed 32-bit multiply/divide; MULTDIV_EARLY_EXC_EN finishes divide-by-zero after one edge
module multdiv_iter
  import multdiv_pkg::*;
(
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY
);
  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH:0]   p_q, p_d, p_step;
  logic [WIDTH-1:0]   m_q, m_d;
  logic               neg_q, neg_d, bz_q, bz_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic               exc_q, exc_d, rdy_q, rdy_d;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quot, fin_res;
  logic               fin_exc;

  multdiv_step u_step (
    .op_div (state_q == S_DIV),
    .p_in   (p_q),
    .m_in   (m_q),
    .p_out  (p_step)
  );

  // Final result: product low word with overflow check, or sign-fixed quotient with div-by-zero/overflow flags
  always_comb begin
    prod    = p_q[2*WIDTH:1];
    quot    = p_q[WIDTH-1:0];
    fin_res = (state_q == S_MUL) ? prod[WIDTH-1:0] : bz_q ? '0 : neg_q ? WIDTH'(-quot) : quot;
    fin_exc = (state_q == S_MUL) ? ~((&prod[2*WIDTH-1:WIDTH-1]) | ~(|prod[2*WIDTH-1:WIDTH-1]))
                                 : bz_q | (~neg_q & (quot == INT_MIN));
  end

  // Next-state: a start pulse always wins and restarts; otherwise iterate, then publish and pulse ready
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    m_d     = m_q;
    neg_d   = neg_q;
    bz_d    = bz_q;
    res_d   = res_q;
    exc_d   = exc_q;
    rdy_d   = 1'b0;
    if (ctrl_MULT | ctrl_DIV) begin
      state_d = ctrl_MULT ? S_MUL : S_DIV;
      cnt_d   = '0;
      m_d     = ctrl_MULT ? data_operandA : mag(data_operandB);
      p_d     = ctrl_MULT ? {{WIDTH{1'b0}}, data_operandB, 1'b0} : {{(WIDTH+1){1'b0}}, mag(data_operandA)};
      neg_d   = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
      bz_d    = ~|data_operandB;
    end else if (state_q == S_MUL || state_q == S_DIV) begin
`ifdef MULTDIV_EARLY_EXC_EN
      if (state_q == S_DIV && bz_q) begin
        state_d = S_DONE;
        res_d   = '0;
        exc_d   = 1'b1;
        rdy_d   = 1'b1;
      end else
`endif
      if (cnt_q <= ITER_LAST) begin
        p_d   = p_step;
        cnt_d = cnt_q + 1'b1;
      end else begin
        state_d = S_DONE;
        res_d   = fin_res;
        exc_d   = fin_exc;
        rdy_d   = 1'b1;
      end
    end else if (state_q == S_DONE) begin
      state_d = S_IDLE;
    end
  end

  // State and registered outputs; reset clears everything immediately
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      p_q     <= '0;
      m_q     <= '0;
      neg_q   <= 1'b0;
      bz_q    <= 1'b0;
      res_q   <= '0;
      exc_q   <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      m_q     <= m_d;
      neg_q   <= neg_d;
      bz_q    <= bz_d;
      res_q   <= res_d;
      exc_q   <= exc_d;
      rdy_q   <= rdy_d;
    end
  end

  assign data_result    = res_q;
  assign data_exception = exc_q;
  assign data_resultRDY = rdy_q;
endmodule

// File: tb/tb_multdiv_iter.sv
// tb_multdiv_iter: randomized and directed checks of multdiv_iter against an arithmetic reference model
module tb_multdiv_iter;
  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] a_in = '0, b_in = '0;
  logic        mult = 1'b0, div = 1'b0;
  logic [31:0] data_result;
  logic        data_exception, data_resultRDY;
  int total = 0, bad = 0;
`ifdef MULTDIV_EARLY_EXC_EN
  localparam int DZ_LAT = 1;
`else
  localparam int DZ_LAT = 33;
`endif

  multdiv_iter dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .data_operandA  (a_in),
    .data_operandB  (b_in),
    .ctrl_MULT      (mult),
    .ctrl_DIV       (div),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY)
  );

  always #5 clock = ~clock;

  function automatic void ref_model(input logic op_div, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] r, output logic e);
    longint p;
    if (!op_div) begin
      p = longint'($signed(a)) * longint'($signed(b));
      r = p[31:0];
      e = (longint'($signed(r)) != p);
    end else if (b == 32'd0) begin
      r = 32'd0;
      e = 1'b1;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      r = 32'h8000_0000;
      e = 1'b1;
    end else begin
      r = $signed(a) / $signed(b);
      e = 1'b0;
    end
  endfunction

  task automatic start_op(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    a_in = a; b_in = b; mult = m; div = d;
    @(posedge clock);
    #1;
    mult = 1'b0; div = 1'b0; a_in = $urandom; b_in = $urandom;
  endtask

  task automatic observe(output int lat, output int pulses, output logic [31:0] r, output logic e);
    lat = -1; pulses = 0; r = '0; e = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clock);
      #1;
      if (data_resultRDY) begin
        pulses++;
        if (lat < 0) begin
          lat = k; r = data_result; e = data_exception;
        end
      end
    end
  endtask

  task automatic do_op(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b,
                       output int lat, output int pulses, output logic [31:0] r, output logic e);
    start_op(m, d, a, b);
    observe(lat, pulses, r, e);
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clock);
    #1;
    total++;
    if ({data_result, data_exception, data_resultRDY} !== 34'd0) begin
      bad++; $display("FAIL reset_outputs got res=%h exc=%b rdy=%b want all 0", data_result, data_exception, data_resultRDY);
    end
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_latency;
    int lat, n; logic [31:0] r; logic e;
    do_op(1'b1, 1'b0, 32'd7, -32'sd3, lat, n, r, e);
    total++; if (lat !== 33) begin bad++; $display("FAIL latency got %0d want 33", lat); end
    total++; if (n !== 1) begin bad++; $display("FAIL rdy_pulses got %0d want 1", n); end
    total++; if (r !== 32'hFFFF_FFEB) begin bad++; $display("FAIL mul_7x-3 got %h want FFFFFFEB", r); end
    total++; if (e !== 1'b0) begin bad++; $display("FAIL mul_7x-3_exc got %b want 0", e); end
  endtask

  task automatic test_mul_overflow;
    int lat, n; logic [31:0] r; logic e;
    do_op(1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000, lat, n, r, e);
    total++; if (r !== 32'h0) begin bad++; $display("FAIL mul_ovf got %h want 00000000", r); end
    total++; if (e !== 1'b1) begin bad++; $display("FAIL mul_ovf_exc got %b want 1", e); end
  endtask

  task automatic test_div_signs;
    logic [31:0] av [3] = '{32'hFFFF_FFF9, 32'd100, 32'h8000_0000};
    logic [31:0] bv [3] = '{32'd2, 32'hFFFF_FFF9, 32'hFFFF_FFFF};
    logic [31:0] rv [3] = '{32'hFFFF_FFFD, 32'hFFFF_FFF2, 32'h8000_0000};
    logic        ev [3] = '{1'b0, 1'b0, 1'b1};
    int lat, n; logic [31:0] r; logic e;
    for (int i = 0; i < 3; i++) begin
      do_op(1'b0, 1'b1, av[i], bv[i], lat, n, r, e);
      total++; if (lat !== 33 || n !== 1) begin bad++; $display("FAIL div_sign%0d_timing got lat=%0d pulses=%0d want 33/1", i, lat, n); end
      total++; if (r !== rv[i] || e !== ev[i]) begin bad++; $display("FAIL div_sign%0d got %h/%b want %h/%b", i, r, e, rv[i], ev[i]); end
    end
  endtask

  task automatic test_div_zero;
    int lat, n; logic [31:0] r; logic e;
    do_op(1'b0, 1'b1, 32'd5, 32'd0, lat, n, r, e);
    total++; if (lat !== DZ_LAT || n !== 1) begin bad++; $display("FAIL div0_timing got lat=%0d pulses=%0d want %0d/1", lat, n, DZ_LAT); end
    total++; if (r !== 32'd0 || e !== 1'b1) begin bad++; $display("FAIL div0 got %h/%b want 00000000/1", r, e); end
  endtask

  task automatic test_random(input logic op_div);
    int lat, n; logic [31:0] a, b, r, er; logic e, ee;
    for (int i = 0; i < 14; i++) begin
      a = (i % 3 == 0) ? 32'($urandom_range(0, 400)) - 32'd200 : $urandom;
      b = (i % 2 == 0) ? 32'($urandom_range(0, 40)) - 32'd20 : $urandom;
      if (i == 5) b = 32'd1;
      if (i == 7) a = 32'h8000_0000;
      ref_model(op_div, a, b, er, ee);
      do_op(~op_div, op_div, a, b, lat, n, r, e);
      total++;
      if (r !== er || e !== ee || n !== 1 || lat !== ((op_div && b == 0) ? DZ_LAT : 33)) begin
        bad++; $display("FAIL rand_%s a=%h b=%h got %h/%b lat=%0d n=%0d want %h/%b", op_div ? "div" : "mul", a, b, r, e, lat, n, er, ee);
      end
    end
  endtask

  task automatic test_restart;
    int lat, n; logic [31:0] r; logic e;
    int early = 0;
    start_op(1'b1, 1'b0, 32'd3, 32'd4);
    for (int k = 1; k <= 9; k++) begin
      @(posedge clock); #1;
      if (data_resultRDY) early++;
    end
    do_op(1'b0, 1'b1, 32'd20, 32'd6, lat, n, r, e);
    total++; if (early !== 0 || n !== 1 || lat !== 33) begin bad++; $display("FAIL restart_timing got early=%0d pulses=%0d lat=%0d want 0/1/33", early, n, lat); end
    total++; if (r !== 32'd3 || e !== 1'b0) begin bad++; $display("FAIL restart_result got %h/%b want 00000003/0", r, e); end
  endtask

  task automatic test_priority;
    int lat, n; logic [31:0] r; logic e;
    do_op(1'b1, 1'b1, 32'd6, 32'd3, lat, n, r, e);
    total++; if (r !== 32'd18 || e !== 1'b0 || lat !== 33) begin bad++; $display("FAIL priority got %h/%b lat=%0d want 00000012/0 lat 33", r, e, lat); end
  endtask

  task automatic test_reset_mid;
    int lat, n; logic [31:0] r; logic e;
    start_op(1'b0, 1'b1, 32'd1000, 32'd7);
    repeat (15) @(posedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    total++;
    if ({data_result, data_exception, data_resultRDY} !== 34'd0) begin
      bad++; $display("FAIL reset_mid got res=%h exc=%b rdy=%b want all 0", data_result, data_exception, data_resultRDY);
    end
    @(negedge clock);
    reset_n = 1'b1;
    observe(lat, n, r, e);
    total++; if (n !== 0 || data_result !== 32'd0) begin bad++; $display("FAIL reset_mid_after got pulses=%0d res=%h want 0/00000000", n, data_result); end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_mul_overflow();
    test_div_signs();
    test_div_zero();
    test_random(1'b0);
    test_random(1'b1);
    test_restart();
    test_priority();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
